// File: rtl/bit_shifter_pkg.sv
// Shared constants and types for the leading-zero-nibble normalizer.
package bit_shifter_pkg;
  localparam int WIDTH = 40;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CW    = 4;

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [CW-1:0]    div_t;
endpackage

// File: rtl/bit_shifter_if.sv
// Data bus of the normalizer: raw value in, normalized value and nibble shift count out.
// There is no valid/ready pair: the slave samples inval on every rising clock edge and
// presents the result one edge later, so a new value is accepted every cycle.
interface bit_shifter_if;
  import bit_shifter_pkg::*;

  data_t inval;
  data_t outval;
  div_t  outdivider;

  modport master (
    output inval,
    input  outval,
    input  outdivider
  );

  modport slave (
    input  inval,
    output outval,
    output outdivider
  );
endinterface

// File: rtl/bit_shifter_lzd_nibble.sv
// Combinational leading-zero-nibble detector: counts all-zero nibbles from the MSB down.
module lzd_nibble
  import bit_shifter_pkg::*;
(
  input  data_t inval,
  output div_t  z
);

  // Scanning upward lets the most significant non-zero nibble take priority;
  // an all-zero input keeps the default of NDIG.
  always_comb begin
    z = div_t'(NDIG);
    for (int i = 0; i < NDIG; i++) begin
      if (inval[i*DIGIT +: DIGIT] != '0) begin
        z = div_t'(NDIG - 1 - i);
      end
    end
  end

endmodule

// File: rtl/bit_shifter.sv
// Registered normalizer: shifts out leading zero nibbles and reports how many were removed.
module bit_shifter
  import bit_shifter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  bit_shifter_if.slave    bus
);

  div_t  z;
  data_t norm;

  lzd_nibble u_lzd (
    .inval (bus.inval),
    .z     (z)
  );

  // Only zero nibbles leave through the top, so the shift never drops data.
  always_comb begin
    norm = bus.inval << (32'(z) * 32'(DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.outval     <= '0;
      bus.outdivider <= '0;
    end else begin
      bus.outval     <= norm;
      bus.outdivider <= z;
    end
  end

endmodule

// File: tb/tb_bit_shifter.sv
// Directed bench for bit_shifter: reset, vector table, back-to-back latency, async reset pulse.
module tb_bit_shifter;
  import bit_shifter_pkg::*;

  typedef struct {
    data_t in;
    data_t exp_val;
    div_t  exp_div;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bit_shifter_if bus ();

  bit_shifter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input data_t act_val, input div_t act_div,
                       input data_t exp_val, input div_t exp_div);
    checks++;
    if (act_val !== exp_val || act_div !== exp_div) begin
      failures++;
      $display("FAIL %s: got outval=%h outdivider=%0d, expected outval=%h outdivider=%0d",
               name, act_val, act_div, exp_val, exp_div);
    end
  endtask

  // Independent reference: repeatedly shift while the top nibble is zero.
  function automatic data_t ref_norm(input data_t v, output div_t d);
    data_t r;
    r = v;
    d = '0;
    while (r[WIDTH-1 -: DIGIT] == '0 && int'(d) < NDIG) begin
      r = r << DIGIT;
      d = d + 1'b1;
    end
    return r;
  endfunction

  // driver: drive at negedge, sample #1 after the following posedge
  task automatic apply(input data_t v);
    @(negedge clk);
    bus.inval = v;
  endtask

  vec_t  vecs[11];
  data_t prev_val;
  div_t  prev_div;
  data_t rv;
  data_t rexp;
  div_t  rdiv;

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{40'h011e2b9946, 40'h11e2b99460, 4'd1};
    vecs[1]  = '{40'h000e2b9946, 40'he2b9946000, 4'd3};
    vecs[2]  = '{40'h00154165e9, 40'h154165e900, 4'd2};
    vecs[3]  = '{40'he2b9946000, 40'he2b9946000, 4'd0};
    vecs[4]  = '{40'h0e2b994600, 40'he2b9946000, 4'd1};
    vecs[5]  = '{40'h0000000001, 40'h1000000000, 4'd9};
    vecs[6]  = '{40'h0000000000, 40'h0000000000, 4'd10};
    vecs[7]  = '{40'hffffffffff, 40'hffffffffff, 4'd0};
    vecs[8]  = '{40'h0000000010, 40'h1000000000, 4'd8};
    vecs[9]  = '{40'h00000f0000, 40'hf000000000, 4'd5};
    vecs[10] = '{40'h8000000000, 40'h8000000000, 4'd0};

    // reset held with a live input
    rst_n     = 1'b0;
    bus.inval = 40'h011e2b9946;
    #1;
    check("reset_async", bus.outval, bus.outdivider, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", bus.outval, bus.outdivider, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", bus.outval, bus.outdivider, 40'h11e2b99460, 4'd1);

    // back-to-back table: result must not appear before the edge, then exactly after it
    prev_val = 40'h11e2b99460;
    prev_div = 4'd1;
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].in);
      #1;
      check($sformatf("hold_%0d", i), bus.outval, bus.outdivider, prev_val, prev_div);
      @(posedge clk);
      #1;
      check($sformatf("vec_%0d", i), bus.outval, bus.outdivider,
            vecs[i].exp_val, vecs[i].exp_div);
      prev_val = vecs[i].exp_val;
      prev_div = vecs[i].exp_div;
    end

    // async reset pulse mid-stream, between edges
    apply(40'h000e2b9946);
    @(posedge clk);
    #1;
    check("pre_pulse", bus.outval, bus.outdivider, 40'he2b9946000, 4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pulse", bus.outval, bus.outdivider, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.inval = 40'h00154165e9;
    #1;
    check("after_pulse_hold", bus.outval, bus.outdivider, '0, '0);
    @(posedge clk);
    #1;
    check("after_pulse", bus.outval, bus.outdivider, 40'h154165e900, 4'd2);

    // randomized leading-zero depth against the reference model
    for (int i = 0; i < 20; i++) begin
      rv = data_t'({$urandom, $urandom});
      rv = rv >> (DIGIT * $urandom_range(0, NDIG - 1));
      rexp = ref_norm(rv, rdiv);
      apply(rv);
      @(posedge clk);
      #1;
      check($sformatf("rand_%0d", i), bus.outval, bus.outdivider, rexp, rdiv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_shifter.md
Name: bit_shifter

Overview:
- Registered leading-zero-digit normalizer for a 40-bit value.
- Each cycle it counts the leading all-zero 4-bit digits (nibbles) of `inval`.
- It shifts `inval` left by that many nibbles, so the most-significant nibble is non-zero.
- It reports the shift count on `outdivider`, which downstream display/scaling logic uses as the exponent/divider.

Parameters:
- WIDTH, 40, data width in bits; must be a multiple of DIGIT.
- DIGIT, 4, digit (shift granularity) width in bits.
- NDIG, WIDTH/DIGIT (10), number of digits; derived, not overridable.
- CW, 4, width of `outdivider`; must satisfy 2^CW > NDIG.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- inval  input  WIDTH  unsigned value to normalize
- outval  output  WIDTH  normalized value, registered
- outdivider  output  CW  number of nibbles shifted, registered

Behaviour:
- Reset: asserting `rst_n` low immediately forces `outval`=0 and `outdivider`=0, with no clock needed. Deassertion is sampled on the next rising edge; the first update happens on the first rising edge with `rst_n` high.
- Leading-zero count `z`:
  - `z` = number of consecutive zero nibbles starting at nibble NDIG-1 (bits 39:36) downward.
  - Range 0..NDIG-1 for non-zero input.
- Shift: `norm` = `inval` << (DIGIT*`z`), zero-filled from the LSB. No bits are lost, because only zero nibbles shift out.
- Zero input: `inval`=0 → `norm`=0, `z`=NDIG (10).
- Registering: on each rising edge with `rst_n` high, `outval`<=`norm` and `outdivider`<=`z`.
  - Latency exactly 1 cycle.
  - Throughput 1 value per cycle, no handshake; a new input is accepted every cycle.
- Input stability: `inval` is sampled only at the clock edge. Changes between edges have no effect on the outputs until the next edge.
- Post-condition for non-zero input: `outval[WIDTH-1:WIDTH-DIGIT]` != 0 and `outval` >> (DIGIT*`outdivider`) == `inval`.
- Implementation: purely combinational priority search (most-significant zero-run detection) followed by a barrel shift and one register stage. No FSM, no multi-cycle iteration.

Decomposition:
- Shared package `bit_shifter_pkg`:
  - WIDTH, DIGIT, NDIG, CW constants.
  - typedef `data_t` (logic [WIDTH-1:0]).
  - typedef `div_t` (logic [CW-1:0]).
- One natural sub-module, `lzd_nibble`: combinational leading-zero-nibble detector, `inval` → `z` (CW bits).
- Barrel shift and output register stay in `bit_shifter`.

Test Plan:
- Reset: hold `rst_n`=0 with `inval`=40'h011e2b9946 → `outval`=0, `outdivider`=0; release, next edge → `outval`=40'h11e2b99460, `outdivider`=1.
- Mixed digits:
  - 40'h000e2b9946 → `outval`=40'he2b9946000, `outdivider`=3.
  - 40'h00154165e9 → `outval`=40'h154165e900, `outdivider`=2.
- Already normalized: 40'he2b9946000 → `outval`=40'he2b9946000, `outdivider`=0; 40'h0e2b994600 → 40'he2b9946000, `outdivider`=1.
- Extremes:
  - 40'h0000000001 → `outval`=40'h1000000000, `outdivider`=9.
  - 40'h0 → `outval`=0, `outdivider`=10.
  - 40'hffffffffff → unchanged, `outdivider`=0.
- Latency/back-to-back: change `inval` every cycle across the vectors above → each result appears exactly one edge later. Apply an async `rst_n` pulse mid-stream → outputs go to 0 immediately, with no clock edge.
